shl_seq: RTL and testbench

SHL_SEQ -- requirements
Module: shl_seq

---
 rtl/shl_seq.sv | 122 ++++++++++++
 tb/tb_shl_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// Purpose : sequential left shifter, moves operand A left by N one bit per cycle and
//           reports condition codes {C,V,N,Z} (bit positions set by the *_mask parameters).
// Latency : N+2 cycles from the start edge to the done pulse (one accept, N shifts, one commit).
// Backpressure: none; start is only sampled in IDLE, so requests while busy/done are dropped.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset, overrides everything (including a same-cycle start)
//   start - operation request, accepted only in IDLE
//   A     - operand, captured when start is accepted
//   N     - shift count, captured when start is accepted
//   R     - registered result A<<N, holds between operations
//   CCR   - registered condition codes, holds between operations
//   busy  - high from the cycle after acceptance until the result commits
//   done  - one-cycle pulse, R/CCR carry the new result in that cycle
//
// op_size must be at least 2: the overflow flag looks at the two top bits of the work register.

module shl_seq #(
  parameter int         op_size  = 4,
  parameter int         cnt_size = 3,
  parameter logic [3:0] c_mask   = 4'b1000,
  parameter logic [3:0] v_mask   = 4'b0100,
  parameter logic [3:0] n_mask   = 4'b0010,
  parameter logic [3:0] z_mask   = 4'b0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [op_size-1:0]  A,
  input  logic [cnt_size-1:0] N,
  output logic [op_size-1:0]  R,
  output logic [3:0]          CCR,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [op_size-1:0]  r_work;
  logic [cnt_size-1:0] r_cnt;
  logic                r_c;
  logic                r_v;

  logic                w_msb;
  logic                w_v_step;
  logic                w_zero;
  logic [3:0]          w_ccr;

  // Carry out of this step is the bit about to leave the top; overflow of this
  // step is a sign change, i.e. the top two bits disagree before the shift.
  assign w_msb    = r_work[op_size-1];
  assign w_v_step = r_work[op_size-1] ^ r_work[op_size-2];
  assign w_zero   = (r_work == '0);

  // Flags are placed by mask so the CCR layout can be rearranged per instance.
  assign w_ccr = ({4{r_c}}    & c_mask)
               | ({4{r_v}}    & v_mask)
               | ({4{w_msb}}  & n_mask)
               | ({4{w_zero}} & z_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      R       <= '0;
      CCR     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_work  <= A;
            r_cnt   <= N;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_cnt != '0) begin
            r_work <= {r_work[op_size-2:0], 1'b0};
            r_c    <= w_msb;
            r_v    <= r_v | w_v_step;
            r_cnt  <= r_cnt - cnt_size'(1);
          end else begin
            // Commit edge: R/CCR change only here (or on reset).
            R       <= r_work;
            CCR     <= w_ccr;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shl_seq.sv
module tb_shl_seq;

  localparam int         OP     = 4;
  localparam int         CNT    = 3;
  localparam logic [3:0] C_MASK = 4'b1000;
  localparam logic [3:0] V_MASK = 4'b0100;
  localparam logic [3:0] N_MASK = 4'b0010;
  localparam logic [3:0] Z_MASK = 4'b0001;

  logic           clk;
  logic           rst;
  logic           start;
  logic [OP-1:0]  A;
  logic [CNT-1:0] N;
  logic [OP-1:0]  R;
  logic [3:0]     CCR;
  logic           busy;
  logic           done;

  int n_vec;
  int n_err;

  shl_seq #(
    .op_size (OP),
    .cnt_size(CNT),
    .c_mask  (C_MASK),
    .v_mask  (V_MASK),
    .n_mask  (N_MASK),
    .z_mask  (Z_MASK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .N    (N),
    .R    (R),
    .CCR  (CCR),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // Reference: A<<N is multiplication by 2**N. The result is the low OP bits, C is the
  // bit that lands just above them (the last one shifted out), and V is signed overflow
  // of A*2**N in OP bits (any sign change along the way sticks).
  function automatic void model(input logic [OP-1:0] a, input int n,
                                output logic [OP-1:0] r, output logic [3:0] ccr);
    longint unsigned up;
    longint          s;
    longint          p;
    logic            c;
    logic            v;
    up  = longint'(a) * (64'd1 << n);
    r   = up[OP-1:0];
    c   = up[OP];
    s   = a[OP-1] ? longint'(a) - (64'sd1 <<< OP) : longint'(a);
    p   = s * (64'sd1 <<< n);
    v   = (p > ((64'sd1 <<< (OP-1)) - 1)) || (p < -(64'sd1 <<< (OP-1)));
    ccr = (c ? C_MASK : 4'b0) | (v ? V_MASK : 4'b0)
        | (r[OP-1] ? N_MASK : 4'b0) | ((r == '0) ? Z_MASK : 4'b0);
  endfunction

  // Drives one operation from an IDLE cycle and observes it; no judging here.
  // lat = edges after the accepting edge until done is seen (-1 on timeout).
  // ign_at >= 0 raises start for one cycle at that point mid-SHIFT; start_in_done
  // raises start during the done cycle. A and N are scrambled right after acceptance.
  task automatic run_op(input logic [OP-1:0] a, input logic [CNT-1:0] n,
                        input int ign_at, input bit start_in_done,
                        output int lat, output logic [OP-1:0] r_o, output logic [3:0] ccr_o,
                        output bit busy_ok, output bit hold_ok,
                        output logic done_next, output logic idle_busy);
    logic [OP-1:0] r0;
    logic [3:0]    c0;
    r0      = R;
    c0      = CCR;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat     = -1;
    A       = a;
    N       = n;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A     = OP'($urandom);
    N     = CNT'($urandom);
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (R !== r0 || CCR !== c0) hold_ok = 1'b0;
      start = (k == ign_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_ok = 1'b0;
    r_o   = R;
    ccr_o = CCR;
    start = start_in_done;
    @(posedge clk); #1;
    start     = 1'b0;
    done_next = done;
    idle_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 4'b1111; N = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    n_vec++; if (R !== 4'b0000) begin n_err++; $display("FAIL reset_R: got %b want 0000", R); end
    n_vec++; if (CCR !== 4'b0000) begin n_err++; $display("FAIL reset_CCR: got %b want 0000", CCR); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_directed();
    logic [OP-1:0] a_t [5];
    logic [CNT-1:0] n_t [5];
    logic [OP-1:0] r_t [5];
    logic [3:0]    c_t [5];
    int lat; logic [OP-1:0] r; logic [3:0] c; bit bok, hok; logic dn, ib;
    a_t = '{4'b0011, 4'b0101, 4'b1000, 4'b1001, 4'b0001};
    n_t = '{3'd1,    3'd2,    3'd1,    3'd0,    3'd6};
    r_t = '{4'b0110, 4'b0100, 4'b0000, 4'b1001, 4'b0000};
    c_t = '{4'b0000, 4'b1100, 4'b1101, 4'b0010, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      run_op(a_t[i], n_t[i], -1, 1'b0, lat, r, c, bok, hok, dn, ib);
      n_vec++; if (r !== r_t[i]) begin n_err++; $display("FAIL dir%0d_R: got %b want %b", i, r, r_t[i]); end
      n_vec++; if (c !== c_t[i]) begin n_err++; $display("FAIL dir%0d_CCR: got %b want %b", i, c, c_t[i]); end
      n_vec++; if (lat != int'(n_t[i]) + 1) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, int'(n_t[i]) + 1); end
      n_vec++; if (!bok) begin n_err++; $display("FAIL dir%0d_busy: got bad busy profile want high until done", i); end
      n_vec++; if (dn !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b want 0", i, dn); end
    end
  endtask

  task automatic test_start_ignored();
    int lat; logic [OP-1:0] r; logic [3:0] c; bit bok, hok; logic dn, ib;
    // Second start mid-SHIFT and another during DONE: neither may start an op.
    run_op(4'b0111, 3'd3, 1, 1'b1, lat, r, c, bok, hok, dn, ib);
    n_vec++; if (r !== 4'b1000) begin n_err++; $display("FAIL ign_R: got %b want 1000", r); end
    n_vec++; if (c !== 4'b1110) begin n_err++; $display("FAIL ign_CCR: got %b want 1110", c); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL ign_latency: got %0d want 4", lat); end
    n_vec++; if (!hok) begin n_err++; $display("FAIL ign_hold: got R/CCR change while busy want held"); end
    n_vec++; if (ib !== 1'b0) begin n_err++; $display("FAIL ign_done_start: got busy=%b want 0", ib); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [OP-1:0] r; logic [3:0] c; bit bok, hok; logic dn, ib;
    bit seen_done;
    run_op(4'b0011, 3'd1, -1, 1'b0, lat, r, c, bok, hok, dn, ib);  // leaves R=0110
    A = 4'b0111; N = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (R !== 4'b0000) begin n_err++; $display("FAIL rstmid_R: got %b want 0000", R); end
    n_vec++; if (CCR !== 4'b0000) begin n_err++; $display("FAIL rstmid_CCR: got %b want 0000", CCR); end
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done !== 1'b0) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (seen_done) begin n_err++; $display("FAIL rstmid_nodone: got done pulse want none"); end
    run_op(4'b0001, 3'd2, -1, 1'b0, lat, r, c, bok, hok, dn, ib);
    n_vec++; if (r !== 4'b0100) begin n_err++; $display("FAIL rstmid_after_R: got %b want 0100", r); end
    n_vec++; if (c !== 4'b0000) begin n_err++; $display("FAIL rstmid_after_CCR: got %b want 0000", c); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL rstmid_after_latency: got %0d want 3", lat); end
  endtask

  task automatic test_reset_in_done();
    int k;
    A = 4'b0110; N = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 20 && done !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rstdone_reach: got done=%b want 1", done); end
    rst = 1'b1; start = 1'b1; A = 4'b0011; N = 3'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstdone_flags: got done=%b busy=%b want 0 0", done, busy); end
    n_vec++; if (R !== 4'b0000 || CCR !== 4'b0000) begin n_err++; $display("FAIL rstdone_out: got R=%b CCR=%b want 0000 0000", R, CCR); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstdone_dropstart: got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    int lat; logic [OP-1:0] r; logic [3:0] c; bit bok, hok; logic dn, ib;
    logic [OP-1:0] a; logic [CNT-1:0] n; logic [OP-1:0] er; logic [3:0] ec; int ign;
    for (int i = 0; i < 60; i++) begin
      a   = OP'($urandom);
      n   = CNT'($urandom_range(0, 7));
      ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(n))) : -1;
      model(a, int'(n), er, ec);
      run_op(a, n, ign, bit'($urandom_range(0, 1)), lat, r, c, bok, hok, dn, ib);
      n_vec++; if (r !== er) begin n_err++; $display("FAIL rnd%0d_R a=%b n=%0d: got %b want %b", i, a, n, r, er); end
      n_vec++; if (c !== ec) begin n_err++; $display("FAIL rnd%0d_CCR a=%b n=%0d: got %b want %b", i, a, n, c, ec); end
      n_vec++; if (lat != int'(n) + 1) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, int'(n) + 1); end
      n_vec++; if (!bok || !hok) begin n_err++; $display("FAIL rnd%0d_busy_hold: got busy_ok=%0d hold_ok=%0d want 1 1", i, bok, hok); end
      n_vec++; if (dn !== 1'b0 || ib !== 1'b0) begin n_err++; $display("FAIL rnd%0d_after_done: got done=%b busy=%b want 0 0", i, dn, ib); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [OP-1:0] r; logic [3:0] c; bit bok, hok; logic dn, ib;
    logic [OP-1:0] er; logic [3:0] ec;
    // Each op starts in the first IDLE cycle after the previous done.
    for (int i = 0; i < 8; i++) begin
      model(OP'(i * 3 + 1), i % 5, er, ec);
      run_op(OP'(i * 3 + 1), CNT'(i % 5), -1, 1'b0, lat, r, c, bok, hok, dn, ib);
      n_vec++; if (r !== er || c !== ec) begin n_err++; $display("FAIL b2b%0d: got R=%b CCR=%b want R=%b CCR=%b", i, r, c, er, ec); end
      n_vec++; if (lat != (i % 5) + 1) begin n_err++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, (i % 5) + 1); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    N     = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_reset_in_done();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
